img_udp_tx: RTL and testbench

Transmit-side counterpart of the Ethernet-to-SDRAM image path. Reads 16-bit RGB565 pixels from the SDRAM controller's read-port FIFO, packs them into 32-bit words and drives the UDP transmitter's start/request handshake. Sends one frame as a sequence of fixed-size UDP packets, one packet per image line by default. Sits between `sdram_top` (read port, clocked by `eth_tx_clk`) and the `udp` module's `tx_*` ports.

---
 rtl/img_udp_tx_pkg.sv | 20 ++
 rtl/pix16_to_32_pack.sv | 52 +++++
 rtl/img_udp_tx.sv | 138 +++++++++++++
 tb/tb_img_udp_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_udp_tx_pkg.sv
// Shared types and constants for the image-to-UDP transmit path.
package img_udp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PREFETCH,
    START,
    SEND,
    GAP
  } state_t;

  localparam int WORD_BYTES    = 4;
  localparam int DEF_PKT_BYTES = 1280;

  function automatic int words_per_pkt(input int pkt_bytes);
    return pkt_bytes / WORD_BYTES;
  endfunction

endpackage

// File: rtl/pix16_to_32_pack.sv
// Fetch unit: one fill reads two RGB565 pixels and packs them big-endian
// into a single 32-bit word held until the transmitter consumes it.
module pix16_to_32_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic        consume,
  input  logic [15:0] rd_data,
  output logic        rd_en,
  output logic [31:0] next_word,
  output logic        valid
);

  logic        p1_reg;
  logic        p2_reg;
  logic        p3_reg;
  logic        valid_reg;
  logic [15:0] hi_reg;
  logic [15:0] lo_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_reg    <= 1'b0;
      p2_reg    <= 1'b0;
      p3_reg    <= 1'b0;
      rd_en     <= 1'b0;
      valid_reg <= 1'b0;
      hi_reg    <= 16'd0;
      lo_reg    <= 16'd0;
    end else begin
      p1_reg <= fill;
      p2_reg <= p1_reg;
      p3_reg <= p2_reg;
      rd_en  <= fill | p1_reg;
      if (p2_reg)
        hi_reg <= rd_data;
      if (p3_reg)
        lo_reg <= rd_data;
      // A new fill discards any stale word left behind by an early tx_done.
      if (fill || consume)
        valid_reg <= 1'b0;
      else if (p3_reg)
        valid_reg <= 1'b1;
    end
  end

  // The low half is forwarded straight from the FIFO in its arrival cycle,
  // so the word is usable on the same edge the flag sets.
  assign next_word = {hi_reg, p3_reg ? rd_data : lo_reg};
  assign valid     = valid_reg | p3_reg;

endmodule

// File: rtl/img_udp_tx.sv
// Frame sequencer: streams SDRAM read-port pixels to the UDP transmitter as
// PKT_NUM fixed-size packets separated by an inter-frame gap.
module img_udp_tx
  import img_udp_tx_pkg::*;
#(
  parameter int PKT_BYTES  = DEF_PKT_BYTES,
  parameter int PKT_NUM    = 480,
  parameter int IFG_CYCLES = 24
) (
  input  logic        eth_tx_clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        rd_ready,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        err_underrun
);

  localparam int         WPP       = words_per_pkt(PKT_BYTES);
  localparam logic [8:0] WPP_W     = 9'(WPP);
  localparam logic [9:0] PKT_NUM_W = 10'(PKT_NUM);
  localparam logic [7:0] IFG_LAST  = 8'(IFG_CYCLES - 1);

  state_t      state;
  logic [8:0]  word_cnt;
  logic [9:0]  pkt_cnt;
  logic [7:0]  ifg_cnt;
  logic [8:0]  word_cnt_inc;
  logic        accept;
  logic        fill;
  logic        valid;
  logic [31:0] next_word;

  assign tx_byte_num  = 16'(PKT_BYTES);
  assign word_cnt_inc = word_cnt + 9'd1;

  always_comb begin
    accept = 1'b0;
    fill   = 1'b0;
    if (state == SEND && tx_req && valid && word_cnt < WPP_W)
      accept = 1'b1;
    if (state == WAIT && rd_ready)
      fill = 1'b1;
    else if (accept && word_cnt_inc < WPP_W)
      fill = 1'b1;
  end

  pix16_to_32_pack u_pack (
    .clk       (eth_tx_clk),
    .rst       (rst),
    .fill      (fill),
    .consume   (accept),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .next_word (next_word),
    .valid     (valid)
  );

  always_ff @(posedge eth_tx_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      word_cnt     <= 9'd0;
      pkt_cnt      <= 10'd0;
      ifg_cnt      <= 8'd0;
      tx_start_en  <= 1'b0;
      tx_data      <= 32'd0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      tx_start_en <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            pkt_cnt <= 10'd0;
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (rd_ready)
            state <= PREFETCH;
        end
        PREFETCH: begin
          if (valid) begin
            tx_start_en <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          word_cnt <= 9'd0;
          state    <= SEND;
        end
        SEND: begin
          if (tx_req) begin
            if (accept) begin
              tx_data  <= next_word;
              word_cnt <= word_cnt_inc;
            end else begin
              tx_data      <= 32'd0;
              err_underrun <= 1'b1;
            end
          end
          if (tx_done) begin
            ifg_cnt <= 8'd0;
            state   <= GAP;
            if ((accept ? word_cnt_inc : word_cnt) < WPP_W)
              err_underrun <= 1'b1;
          end
        end
        GAP: begin
          if (ifg_cnt == IFG_LAST) begin
            pkt_cnt <= pkt_cnt + 10'd1;
            if (pkt_cnt + 10'd1 < PKT_NUM_W) begin
              state <= WAIT;
            end else begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_udp_tx.sv
// Self-checking bench for img_udp_tx: ramp FIFO, MII-paced UDP model and a
// rule-based reference for payload words, underruns and FIFO pops.
module tb_img_udp_tx;

  localparam int PKT_BYTES  = 16;
  localparam int PKT_NUM    = 2;
  localparam int IFG_CYCLES = 4;
  localparam int WPP        = PKT_BYTES / 4;

  logic        eth_tx_clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        rd_ready = 1'b0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic [15:0] rd_data = 16'd0;
  logic        rd_en;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  logic        busy;
  logic        frame_done;
  logic        err_underrun;

  img_udp_tx #(
    .PKT_BYTES  (PKT_BYTES),
    .PKT_NUM    (PKT_NUM),
    .IFG_CYCLES (IFG_CYCLES)
  ) dut (
    .eth_tx_clk   (eth_tx_clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .rd_ready     (rd_ready),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .tx_start_en  (tx_start_en),
    .tx_byte_num  (tx_byte_num),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .tx_done      (tx_done),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_underrun (err_underrun)
  );

  always #5 eth_tx_clk = ~eth_tx_clk;

  // Ramp FIFO and event counters
  logic [15:0] ramp = 16'h0001;
  int rd_cnt = 0;
  int start_cnt = 0;
  int done_cnt = 0;

  always @(posedge eth_tx_clk) begin
    if (rd_en) begin
      rd_data <= ramp;
      ramp    <= ramp + 16'd1;
      rd_cnt  <= rd_cnt + 1;
    end
    if (tx_start_en) start_cnt <= start_cnt + 1;
    if (frame_done)  done_cnt  <= done_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          exp_rd;
  logic        exp_err;
  int          lat_rd;
  int          lat_start[PKT_NUM];
  int          stall_rd;
  int          stall_start;
  logic        busy_stall;
  logic        busy_at_done;
  int          timeouts;

  task automatic tick;
    @(posedge eth_tx_clk);
    #1;
  endtask

  // Reference: each packet prefetches one word; a request is served only if
  // fewer than WPP words went out and the previous served request is at least
  // 3 cycles old (refill latency). Every fill pops two pixels.
  task automatic model_frame(input int spacing, input int nreq, input logic [15:0] base);
    int ptr;
    int words;
    int last;
    int t;
    logic [31:0] pre;
    exp_q.delete();
    exp_err = 1'b0;
    ptr = 0;
    for (int p = 0; p < PKT_NUM; p++) begin
      words = 0;
      last  = 0;
      pre   = {base + 16'(ptr), base + 16'(ptr + 1)};
      ptr  += 2;
      for (int r = 0; r < nreq; r++) begin
        t = r * spacing;
        if (words < WPP && (words == 0 || t - last >= 3)) begin
          exp_q.push_back(pre);
          words++;
          last = t;
          if (words < WPP) begin
            pre  = {base + 16'(ptr), base + 16'(ptr + 1)};
            ptr += 2;
          end
        end else begin
          exp_q.push_back(32'd0);
          exp_err = 1'b1;
        end
      end
      if (words < WPP) exp_err = 1'b1;
    end
    exp_rd = ptr;
  endtask

  task automatic serve_packet(input int spacing, input int nreq);
    tick;
    for (int r = 0; r < nreq; r++) begin
      tx_req = 1'b1;
      tick;
      tx_req = 1'b0;
      got_q.push_back(tx_data);
      $display("[TB] tx_req %0d -> tx_data %08h", r, tx_data);
      repeat (spacing - 1) tick;
    end
    repeat (2) tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
  endtask

  task automatic run_frame(input int spacing, input int nreq, input int stall, input logic inject);
    int n;
    int rd0;
    int s0;
    got_q.delete();
    timeouts = 0;
    lat_rd = -1;
    busy_at_done = 1'b1;
    rd_ready = (stall == 0);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    if (stall > 0) begin
      rd0 = rd_cnt;
      s0  = start_cnt;
      repeat (stall) tick;
      stall_rd    = rd_cnt - rd0;
      stall_start = start_cnt - s0;
      busy_stall  = busy;
      rd_ready    = 1'b1;
    end
    for (int p = 0; p < PKT_NUM; p++) begin
      n = 0;
      while (!rd_en && n < 200) begin tick; n++; end
      if (n >= 200) timeouts++;
      if (p == 0) lat_rd = n;
      n = 0;
      while (!tx_start_en && n < 200) begin tick; n++; end
      if (n >= 200) timeouts++;
      lat_start[p] = n;
      $display("[TB] packet %0d start after %0d cycles", p, n);
      if (inject && p == 0) begin
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
      end
      serve_packet(spacing, nreq);
    end
    n = 0;
    while (!frame_done && n < 200) begin tick; n++; end
    if (n >= 200) timeouts++;
    busy_at_done = busy;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    tests++; if (tx_start_en !== 1'b0) begin fails++; $display("FAIL reset_tx_start_en: got %b expected 0", tx_start_en); end
    tests++; if (tx_data !== 32'd0) begin fails++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
    tests++; if (tx_byte_num !== 16'(PKT_BYTES)) begin fails++; $display("FAIL reset_tx_byte_num: got %0d expected %0d", tx_byte_num, PKT_BYTES); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    tests++; if (err_underrun !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_underrun); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [15:0] base;
    int rd0, s0, d0;
    base = ramp; rd0 = rd_cnt; s0 = start_cnt; d0 = done_cnt;
    run_frame(8, 4, 0, 1'b0);
    model_frame(8, 4, base);
    tests++; if (timeouts !== 0) begin fails++; $display("FAIL basic_timeout: got %0d expected 0", timeouts); end
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL basic_word%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
    tests++; if (rd_cnt - rd0 !== exp_rd) begin fails++; $display("FAIL basic_rd_en: got %0d expected %0d", rd_cnt - rd0, exp_rd); end
    tests++; if (start_cnt - s0 !== PKT_NUM) begin fails++; $display("FAIL basic_starts: got %0d expected %0d", start_cnt - s0, PKT_NUM); end
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_frame_done: got %0d expected 1", done_cnt - d0); end
    tests++; if (busy_at_done !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
    // frame_start cycle to first rd_en is 2 cycles: one edge past the sampling edge
    tests++; if (lat_rd !== 1) begin fails++; $display("FAIL basic_lat_rd: got %0d expected 1", lat_rd); end
    tests++; if (lat_start[0] !== 3) begin fails++; $display("FAIL basic_lat_start0: got %0d expected 3", lat_start[0]); end
    tests++; if (lat_start[1] !== 3) begin fails++; $display("FAIL basic_lat_start1: got %0d expected 3", lat_start[1]); end
    tests++; if (err_underrun !== exp_err) begin fails++; $display("FAIL basic_err: got %b expected %b", err_underrun, exp_err); end
  endtask

  task automatic test_stall;
    logic [15:0] base;
    base = ramp;
    run_frame(8, 4, 50, 1'b0);
    model_frame(8, 4, base);
    tests++; if (timeouts !== 0) begin fails++; $display("FAIL stall_timeout: got %0d expected 0", timeouts); end
    tests++; if (stall_rd !== 0) begin fails++; $display("FAIL stall_rd_en: got %0d expected 0", stall_rd); end
    tests++; if (stall_start !== 0) begin fails++; $display("FAIL stall_start: got %0d expected 0", stall_start); end
    tests++; if (busy_stall !== 1'b1) begin fails++; $display("FAIL stall_busy: got %b expected 1", busy_stall); end
    tests++; if (lat_start[0] !== 3) begin fails++; $display("FAIL stall_lat_start: got %0d expected 3", lat_start[0]); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL stall_word%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] base;
    int s0, d0;
    base = ramp; s0 = start_cnt; d0 = done_cnt;
    run_frame(8, 4, 0, 1'b1);
    model_frame(8, 4, base);
    tests++; if (start_cnt - s0 !== 2) begin fails++; $display("FAIL b2b_starts: got %0d expected 2", start_cnt - s0); end
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL b2b_frame_done: got %0d expected 1", done_cnt - d0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_word%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_early_done;
    logic [15:0] base;
    int rd0, s0;
    tests++; if (err_underrun !== 1'b0) begin fails++; $display("FAIL early_err_before: got %b expected 0", err_underrun); end
    base = ramp; rd0 = rd_cnt; s0 = start_cnt;
    run_frame(8, 2, 0, 1'b0);
    model_frame(8, 2, base);
    tests++; if (timeouts !== 0) begin fails++; $display("FAIL early_timeout: got %0d expected 0", timeouts); end
    tests++; if (err_underrun !== exp_err) begin fails++; $display("FAIL early_err: got %b expected %b", err_underrun, exp_err); end
    tests++; if (start_cnt - s0 !== PKT_NUM) begin fails++; $display("FAIL early_starts: got %0d expected %0d", start_cnt - s0, PKT_NUM); end
    tests++; if (rd_cnt - rd0 !== exp_rd) begin fails++; $display("FAIL early_rd_en: got %0d expected %0d", rd_cnt - rd0, exp_rd); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL early_word%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_rst_midpacket;
    logic [15:0] base;
    int n, s0;
    rd_ready = 1'b1;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    n = 0;
    while (!tx_start_en && n < 200) begin tick; n++; end
    tests++; if (n >= 200) begin fails++; $display("FAIL rstmid_start_timeout: got %0d expected <200", n); end
    tick;
    tx_req = 1'b1;
    tick;
    tx_req = 1'b0;
    $display("[TB] rst asserted in SEND, rd_en=%b tx_data=%08h", rd_en, tx_data);
    rst = 1'b1;
    #1;
    tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL rstmid_rd_en: got %b expected 0", rd_en); end
    tests++; if (tx_start_en !== 1'b0) begin fails++; $display("FAIL rstmid_tx_start_en: got %b expected 0", tx_start_en); end
    tests++; if (tx_data !== 32'd0) begin fails++; $display("FAIL rstmid_tx_data: got %h expected 0", tx_data); end
    tests++; if (tx_byte_num !== 16'(PKT_BYTES)) begin fails++; $display("FAIL rstmid_tx_byte_num: got %0d expected %0d", tx_byte_num, PKT_BYTES); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rstmid_frame_done: got %b expected 0", frame_done); end
    tests++; if (err_underrun !== 1'b0) begin fails++; $display("FAIL rstmid_err: got %b expected 0", err_underrun); end
    repeat (2) tick;
    rst = 1'b0;
    s0 = start_cnt;
    repeat (30) tick;
    tests++; if (start_cnt - s0 !== 0) begin fails++; $display("FAIL rstmid_no_restart: got %0d expected 0", start_cnt - s0); end
    base = ramp;
    run_frame(8, 4, 0, 1'b0);
    model_frame(8, 4, base);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL rstmid_word%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
    tests++; if (err_underrun !== 1'b0) begin fails++; $display("FAIL rstmid_clean_err: got %b expected 0", err_underrun); end
  endtask

  task automatic test_underrun;
    logic [15:0] base;
    int rd0;
    base = ramp; rd0 = rd_cnt;
    run_frame(2, 4, 0, 1'b0);
    model_frame(2, 4, base);
    tests++; if (timeouts !== 0) begin fails++; $display("FAIL underrun_timeout: got %0d expected 0", timeouts); end
    tests++; if (err_underrun !== exp_err) begin fails++; $display("FAIL underrun_err: got %b expected %b", err_underrun, exp_err); end
    tests++; if (rd_cnt - rd0 !== exp_rd) begin fails++; $display("FAIL underrun_rd_en: got %0d expected %0d", rd_cnt - rd0, exp_rd); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL underrun_word%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_back_to_back;
    test_early_done;
    test_rst_midpacket;
    test_underrun;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
